// File: rtl/mp_add_sequencer.sv
// Multi-precision add/sub sequencer driving an external N-bit ripple adder.
// Optional ZERO result flag enabled by defining MP_ZERO_FLAG_EN.
module mp_add_sequencer #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          SUB,
  input  logic [AW-1:0] LEN,
  output logic [AW-1:0] A_ADDR,
  output logic [AW-1:0] B_ADDR,
  input  logic [N-1:0]  A_DATA,
  input  logic [N-1:0]  B_DATA,
  output logic [N-1:0]  ADD_A,
  output logic [N-1:0]  ADD_B,
  output logic          ADD_CIN,
  input  logic [N-1:0]  ADD_SUM,
  output logic [AW-1:0] R_ADDR,
  output logic [N-1:0]  R_DATA,
  output logic          R_WE,
  output logic          BUSY,
  output logic          DONE,
  output logic          COUT
`ifdef MP_ZERO_FLAG_EN
  ,
  output logic          ZERO
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_FIN
  } state_t;

  localparam logic [AW-1:0] A_ONE = AW'(1);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] k_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] addr_q;
  logic          sub_q;
  logic          carry_q;
  logic          cout_q;
  logic          last;
  logic          c_out;
  logic          a_msb;
  logic          b_msb;
  logic          s_msb;
  logic          busy_c;
  logic          done_c;
  logic          we_c;

`ifdef MP_ZERO_FLAG_EN
  logic          zacc_q;
  logic          zero_q;
  logic          sum_zero;

  assign sum_zero = (ADD_SUM == '0);
  assign ZERO     = zero_q;
`endif

  assign last = (k_q == len_q);

  // Adder hookup: B is inverted for subtraction, carry-in comes from the carry register.
  assign ADD_A   = A_DATA;
  assign ADD_B   = B_DATA ^ {N{sub_q}};
  assign ADD_CIN = carry_q;

  // The adder exports no carry, so rebuild it from the operand and sum MSBs.
  assign a_msb = ADD_A[N-1];
  assign b_msb = ADD_B[N-1];
  assign s_msb = ADD_SUM[N-1];
  assign c_out = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);

  assign A_ADDR = addr_q;
  assign B_ADDR = addr_q;
  assign R_ADDR = k_q;
  assign R_DATA = ADD_SUM;
  assign R_WE   = we_c;
  assign BUSY   = busy_c;
  assign DONE   = done_c;
  assign COUT   = cout_q;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    we_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy_c  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy_c = 1'b1;
        we_c   = 1'b1;
        if (last) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand latches, word counter, read address and inter-word carry.
  // The read address runs one word ahead of k so read data is never stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sub_q   <= 1'b0;
      len_q   <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            sub_q   <= SUB;
            len_q   <= LEN;
            k_q     <= '0;
            addr_q  <= '0;
            carry_q <= SUB;
          end
        end
        S_FETCH: begin
          addr_q <= addr_q + A_ONE;
        end
        S_EXEC: begin
          addr_q  <= addr_q + A_ONE;
          carry_q <= c_out;
          if (last) begin
            cout_q <= c_out ^ sub_q;
          end else begin
            k_q <= k_q + A_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MP_ZERO_FLAG_EN
  // Zero accumulator over all result words, published on the last word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      zacc_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          zacc_q <= 1'b1;
        end
        S_EXEC: begin
          zacc_q <= zacc_q & sum_zero;
          if (last) begin
            zero_q <= zacc_q & sum_zero;
          end
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer with behavioural memories and adder.
// Expected writes/completions are queued by stimulus and popped by a monitor.
module tb_mp_add_sequencer;

  localparam int N  = 16;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          SUB = 1'b0;
  logic [AW-1:0] LEN = '0;
  logic [AW-1:0] A_ADDR;
  logic [AW-1:0] B_ADDR;
  logic [N-1:0]  A_DATA;
  logic [N-1:0]  B_DATA;
  logic [N-1:0]  ADD_A;
  logic [N-1:0]  ADD_B;
  logic          ADD_CIN;
  logic [N-1:0]  ADD_SUM;
  logic [AW-1:0] R_ADDR;
  logic [N-1:0]  R_DATA;
  logic          R_WE;
  logic          BUSY;
  logic          DONE;
  logic          COUT;
`ifdef MP_ZERO_FLAG_EN
  logic          ZERO;
`endif

  mp_add_sequencer #(.N(N), .AW(AW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SUB    (SUB),
    .LEN    (LEN),
    .A_ADDR (A_ADDR),
    .B_ADDR (B_ADDR),
    .A_DATA (A_DATA),
    .B_DATA (B_DATA),
    .ADD_A  (ADD_A),
    .ADD_B  (ADD_B),
    .ADD_CIN(ADD_CIN),
    .ADD_SUM(ADD_SUM),
    .R_ADDR (R_ADDR),
    .R_DATA (R_DATA),
    .R_WE   (R_WE),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .COUT   (COUT)
`ifdef MP_ZERO_FLAG_EN
    ,
    .ZERO   (ZERO)
`endif
  );

  always #5 CLK = ~CLK;

  logic [N-1:0] mem_a [16];
  logic [N-1:0] mem_b [16];
  logic [N-1:0] mem_r [16];
  logic [N-1:0] exp_r [16];

  always @(posedge CLK) begin
    A_DATA <= mem_a[A_ADDR];
    B_DATA <= mem_b[B_ADDR];
    if (R_WE) mem_r[R_ADDR] <= R_DATA;
  end

  assign ADD_SUM = ADD_A + ADD_B + {{(N-1){1'b0}}, ADD_CIN};

  typedef struct {
    bit            is_done;
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
    logic          cout;
    logic          zero;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && (R_WE || DONE)) begin
      if (R_WE) wr_cnt++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: we=%b done=%b addr=%0h", R_WE, DONE, R_ADDR);
      end else begin
        me = q.pop_front();
        chk("out_kind", {31'b0, DONE}, {31'b0, me.is_done});
        if (R_WE) begin
          chk("r_addr", {28'b0, R_ADDR}, {28'b0, me.addr});
          chk("r_data", {16'b0, R_DATA}, {16'b0, me.data});
        end
        if (DONE) begin
          chk("cout", {31'b0, COUT}, {31'b0, me.cout});
`ifdef MP_ZERO_FLAG_EN
          chk("zero", {31'b0, ZERO}, {31'b0, me.zero});
`endif
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
      exp_r[i] = '0;
    end
  endtask

  task automatic run_op(input logic sub, input int len, input logic ec,
                        input logic ez, input int mid_start);
    int busy_n;
    int done_cyc;
    int w0;
    for (int i = 0; i <= len; i++)
      q.push_back('{1'b0, AW'(i), exp_r[i], 1'b0, 1'b0});
    q.push_back('{1'b1, '0, '0, ec, ez});
    w0 = wr_cnt;
    @(posedge CLK);
    #1 START = 1'b1;
    SUB = sub;
    LEN = AW'(len);
    @(posedge CLK);
    #1 START = 1'b0;
    SUB = ~sub;
    LEN = ~LEN;
    busy_n = 0;
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (BUSY) busy_n++;
      if (DONE) begin
        done_cyc = c;
        break;
      end
      START = (c == mid_start);
    end
    START = 1'b0;
    chk("done_cycle", done_cyc, len + 3);
    chk("busy_cycles", busy_n, len + 2);
    @(negedge CLK);
    chk("idle_after", {30'b0, BUSY, DONE}, 0);
    chk("cout_hold", {31'b0, COUT}, {31'b0, ec});
    chk("write_count", wr_cnt - w0, len + 1);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_r[i] = '0;
    clear_mem();
    #2;
    chk("rst_busy", {31'b0, BUSY}, 0);
    chk("rst_done", {31'b0, DONE}, 0);
    chk("rst_we", {31'b0, R_WE}, 0);
    chk("rst_cout", {31'b0, COUT}, 0);
    chk("rst_addr", {24'b0, A_ADDR, R_ADDR}, 0);
    chk("rst_cin", {31'b0, ADD_CIN}, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // 1: 1 + 2
    clear_mem();
    mem_a[0] = 16'h0001; mem_b[0] = 16'h0002; exp_r[0] = 16'h0003;
    run_op(1'b0, 0, 1'b0, 1'b0, 0);

    // 2: FFFF + 1 carries out of the MSB
    clear_mem();
    mem_a[0] = 16'hFFFF; mem_b[0] = 16'h0001; exp_r[0] = 16'h0000;
    run_op(1'b0, 0, 1'b1, 1'b1, 0);

    // 3: carry propagates into word 1
    clear_mem();
    mem_a[0] = 16'hFFFF; mem_b[0] = 16'h0001; exp_r[0] = 16'h0000;
    exp_r[1] = 16'h0001;
    run_op(1'b0, 1, 1'b0, 1'b0, 0);

    // 4a: 0x1_0000 - 0x0_0001
    clear_mem();
    mem_a[1] = 16'h0001; mem_b[0] = 16'h0001;
    exp_r[0] = 16'hFFFF; exp_r[1] = 16'h0000;
    run_op(1'b1, 1, 1'b0, 1'b0, 0);

    // 4b: 0 - 1 borrows
    clear_mem();
    mem_b[0] = 16'h0001; exp_r[0] = 16'hFFFF;
    run_op(1'b1, 0, 1'b1, 1'b0, 0);

    // 5: full-length ripple, with a stray START mid-run
    clear_mem();
    for (int i = 0; i < 16; i++) mem_a[i] = 16'hFFFF;
    mem_b[0] = 16'h0001;
    run_op(1'b0, 15, 1'b1, 1'b1, 6);
    repeat (3) @(negedge CLK);
    chk("stray_start_ignored", {31'b0, BUSY}, 0);

    // 6: reset during EXEC of word 3 of a LEN=7 add
    clear_mem();
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = N'(i + 1);
      mem_b[i] = 16'h0010;
    end
    mem_r[3] = 16'hDEAD;
    for (int i = 0; i < 3; i++)
      q.push_back('{1'b0, AW'(i), N'(i + 'h11), 1'b0, 1'b0});
    @(posedge CLK);
    #1 START = 1'b1;
    SUB = 1'b0;
    LEN = AW'(7);
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("pre_rst_k3", {27'b0, R_WE, R_ADDR}, {27'b0, 1'b1, 4'd3});
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, BUSY}, 0);
    chk("mid_rst_we", {31'b0, R_WE}, 0);
    chk("mid_rst_done", {31'b0, DONE}, 0);
    chk("mid_rst_cout", {31'b0, COUT}, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("no_write_k3", {16'b0, mem_r[3]}, 32'h0000DEAD);
    chk("rst_queue", q.size(), 0);

    // 6b: clean op after abandoned run
    clear_mem();
    mem_a[0] = 16'h0005; mem_b[0] = 16'h0006; exp_r[0] = 16'h000B;
    run_op(1'b0, 0, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
